manchester_receiver: RTL
========================

Name: manchester_receiver

Overview:
- Receive-side counterpart to the Manchester sender chain; consumes the single-wire line produced by the serializer, in the same aclk domain.
- Synchronizes the line and recovers bit timing from mid-bit transitions.
- Locks onto the 0x55 preamble, hunts for the sync word, and deserializes payload bytes MSB-first.
- Emits bytes on an AXI-Stream master with tlast marking end of frame; end of frame is detected by carrier loss.

Parameters:
- HALF_BIT_CYCLES, 8: aclk cycles per Manchester half-bit; must be >= 4 and even.
- SYNC_WORD, 8'hD5: decoded byte that ends the preamble and starts the payload.
- INVERT, 0: 0 means 1 = low-to-high mid-bit edge, 0 = high-to-low; 1 swaps both.

Ports:
- aclk, input, 1: sole clock.
- aresetn, input, 1: asynchronous, active-low reset.
- serial_in, input, 1: Manchester line; asynchronous to bit timing.
- m_axis_tdata, output, 8: received byte.
- m_axis_tvalid, output, 1: output beat valid.
- m_axis_tready, input, 1: downstream ready.
- m_axis_tlast, output, 1: last byte of frame.
- overflow, output, 1: one-cycle pulse; a byte was dropped because the output register was full.
- frame_error, output, 1: one-cycle pulse; frame ended on a partial byte or a code violation.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0, frame_error=0.
  - Internals: 2-flop synchronizer=0, state=IDLE, pend_valid=0, all counters=0.
- Input path:
  - serial_in passes through a 2-flop synchronizer, then one edge-detect register.
  - An edge is seen 3 cycles after the line toggles.
- Timer t_mid:
  - Counts cycles since the last mid-bit edge and saturates at 5*HALF_BIT_CYCLES/2.
  - Width is clog2(5*HALF_BIT_CYCLES/2 + 1).
- Edge classification (outside IDLE):
  - t_mid < HALF/2: glitch, i.e. code violation.
  - HALF/2 <= t_mid < 3*HALF/2: boundary edge; ignored, timer continues.
  - t_mid >= 3*HALF/2: mid-bit edge; decode one bit from the edge direction (per INVERT) and clear t_mid.
- Carrier loss: t_mid reaches 5*HALF/2.
- IDLE:
  - The first edge of either polarity is taken as a mid-bit edge.
  - Decode its bit, clear t_mid, go to HUNT.
  - Locking is valid because 0x55 contains only mid-bit transitions.
- HUNT:
  - Each decoded bit shifts into an 8-bit shift register, MSB-first.
  - Shift register == SYNC_WORD: go to DATA, bitcnt=0.
  - Carrier loss or glitch: back to IDLE; no output, no error pulse.
- DATA:
  - Bits are assembled MSB-first; bitcnt 0..7 wraps.
  - When the 8th bit completes:
    - If pend_valid, push pend with tlast=0.
    - Then load the new byte into pend and set pend_valid=1.
    - Both happen in the same cycle.
- End of frame (DATA only), on carrier loss or glitch:
  - If pend_valid, push pend with tlast=1.
  - If bitcnt != 0 or a glitch caused the end, pulse frame_error; partial bits are discarded.
  - Clear pend_valid and go to IDLE.
  - A frame with zero complete bytes produces no beat.
- Push into the output register:
  - If m_axis_tvalid=0, or m_axis_tready=1 in that cycle: load tdata/tlast and set tvalid=1 the next cycle.
  - Otherwise: drop the byte and pulse overflow. If the dropped byte carried tlast=1, force the held beat's m_axis_tlast to 1 so the frame still closes.
- Output handshake:
  - m_axis_tvalid clears on tvalid&&tready when no push occurs in that cycle.
  - tdata and tlast are stable while tvalid=1 && !tready, except the forced-tlast case above.
- Latency: a byte appears on the output 1 cycle after the next byte's 8th mid-bit edge is detected, or 1 cycle after carrier loss.
- Throughput: one byte per 16*HALF cycles; the output register absorbs up to 16*HALF-1 cycles of backpressure per byte.
- Simultaneous events: a push and an output handshake in the same cycle load the new byte with tvalid staying 1 (no bubble).
- Mid-frame reset: all state is discarded immediately and no beat is emitted. After release, the receiver resynchronizes on the next preamble.

Test Plan:
1. HALF=8. Send 7×0x55, 0xD5, 0x01, 0x02, 0x03, then idle high with tready=1 -> exactly 3 beats: 0x01/0, 0x02/0, 0x03/tlast=1; no overflow, no frame_error.
2. Same frame with tready=0 throughout -> one beat 0x01 held with tlast forced 1; overflow pulses twice (drops of 0x02 and 0x03); after tready=1, a single handshake leaves tvalid=0.
3. Preamble only (16×0x55), then idle -> no beats, no pulses, state returns to IDLE; a following valid frame with payload 0xA5 yields 0xA5/tlast=1.
4. Sync, payload 0xAA, then 4 more bits, then idle -> beat 0xAA/tlast=1; frame_error pulses once.
5. Sync, payload 0x3C, 0xC3, then a 1-cycle glitch mid-third-byte -> 0x3C/0, 0xC3/1; frame_error pulse; the next preamble re-locks.
6. Assert aresetn low mid-payload for 2 cycles with tvalid=1 held -> tvalid/tlast/tdata are 0 asynchronously; no stale beat after release; the next frame 0x55…0xD5, 0x7E decodes to 0x7E/tlast=1.

Source files
------------

// File: rtl/manchester_receiver.sv
// manchester_receiver: Manchester line decoder with preamble lock, sync-word hunt and AXI-Stream byte output
module manchester_receiver #(
    parameter int         HALF_BIT_CYCLES = 8,
    parameter logic [7:0] SYNC_WORD       = 8'hD5,
    parameter bit         INVERT          = 1'b0
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       serial_in,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       overflow,
    output logic       frame_error
);
    localparam int SAT = 5 * HALF_BIT_CYCLES / 2;
    localparam int TW  = $clog2(SAT + 1);
    localparam logic [TW-1:0] T_SAT = TW'(SAT);
    localparam logic [TW-1:0] T_GL  = TW'(HALF_BIT_CYCLES / 2);
    localparam logic [TW-1:0] T_MID = TW'(3 * HALF_BIT_CYCLES / 2);

    typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;

    state_t        state, state_n;
    logic          s1, s2, s3;
    logic [TW-1:0] t_mid;
    logic [7:0]    shreg, shreg_n, pend, pend_n, shift_in;
    logic [2:0]    bitcnt, bitcnt_n;
    logic          pend_valid, pend_valid_n;
    logic          edge_det, bit_val, carrier_loss, glitch, mid_edge;
    logic          push, push_last, ferr;

    assign edge_det     = s2 ^ s3;
    assign bit_val      = s2 ^ INVERT;
    assign shift_in     = {shreg[6:0], bit_val};
    assign carrier_loss = (state != IDLE) && (t_mid == T_SAT);
    assign glitch       = (state != IDLE) && edge_det && !carrier_loss && (t_mid < T_GL);
    // In IDLE any edge is trusted as mid-bit: the 0x55 preamble has no boundary edges
    assign mid_edge     = edge_det && ((state == IDLE) || (!carrier_loss && t_mid >= T_MID));

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bitcnt_n     = bitcnt;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        push         = 1'b0;
        push_last    = 1'b0;
        ferr         = 1'b0;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    shreg_n = {7'b0, bit_val};
                    state_n = HUNT;
                end
            end
            HUNT: begin
                if (carrier_loss || glitch) begin
                    state_n = IDLE;
                end else if (mid_edge) begin
                    shreg_n = shift_in;
                    if (shift_in == SYNC_WORD) begin
                        state_n  = DATA;
                        bitcnt_n = 3'd0;
                    end
                end
            end
            DATA: begin
                if (carrier_loss || glitch) begin
                    push         = pend_valid;
                    push_last    = 1'b1;
                    ferr         = glitch || (bitcnt != 3'd0);
                    pend_valid_n = 1'b0;
                    state_n      = IDLE;
                end else if (mid_edge) begin
                    shreg_n  = shift_in;
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) begin
                        push         = pend_valid;
                        pend_n       = shift_in;
                        pend_valid_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            t_mid         <= '0;
            state         <= IDLE;
            shreg         <= '0;
            bitcnt        <= '0;
            pend          <= '0;
            pend_valid    <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            overflow      <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            s1         <= serial_in;
            s2         <= s1;
            s3         <= s2;
            t_mid      <= mid_edge ? '0 : (t_mid == T_SAT ? t_mid : t_mid + 1'b1);
            state      <= state_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            if (push && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= pend;
                m_axis_tlast  <= push_last;
                m_axis_tvalid <= 1'b1;
            end else if (push) begin
                if (push_last) m_axis_tlast <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            overflow    <= push && m_axis_tvalid && !m_axis_tready;
            frame_error <= ferr;
        end
    end
endmodule
